// File: rtl/shift_seq.sv
// shift_seq: shift/rotate engine (SLL/SRL/SLA/SRA/ROL/ROR/PASS) with parity, zero and SLA overflow flags; optional macro SHIFT_SEQ_BARREL_EN.
// Latency: effective amount + 1 edges from accept (PASS / amount 0: 1 edge); with SHIFT_SEQ_BARREL_EN every command takes 1 edge.
// Backpressure: accepts only in IDLE; the result is held in HOLD until out_ready, with in_ready low meanwhile.
module shift_seq #(
    parameter int WIDTH = 9,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic             out_zero,
    output logic             out_ovf,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SLA = 3'd2;
    localparam logic [2:0] OP_SRA = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] data_q;
    logic             ovf_q;
    logic             accept;
    logic             is_pass;
    logic [31:0]      amt_raw;
    logic [31:0]      eff_amt;
    logic [CNT_W-1:0] eff_cnt;

    assign accept  = in_valid && (state == IDLE);
    assign is_pass = in_op[2] & in_op[1];

    // Effective amount: saturate at WIDTH for shifts, modulo WIDTH for rotates
    always_comb begin
        amt_raw = 32'(in_amt);
        eff_amt = amt_raw;
        if (in_op == OP_ROL || in_op == OP_ROR) begin
            eff_amt = amt_raw % 32'(WIDTH);
        end else if (amt_raw > 32'(WIDTH)) begin
            eff_amt = 32'(WIDTH);
        end
        eff_cnt = CNT_W'(eff_amt);
    end

`ifdef SHIFT_SEQ_BARREL_EN
    logic [WIDTH-1:0] bar_data;
    logic [WIDTH:0]   ovf_ext;
    logic [WIDTH:0]   ovf_mask;
    logic             bar_ovf;

    // Whole effective shift in one pass straight from the command inputs.
    // The operand is extended by one zero below the LSB so that a full-width
    // SLA also sees the zero that finally reaches the MSB.
    always_comb begin
        ovf_ext  = {in_data, 1'b0};
        ovf_mask = ~({(WIDTH + 1){1'b1}} >> (eff_amt + 32'd1));
        bar_ovf  = |((ovf_ext ^ {(WIDTH + 1){in_data[WIDTH-1]}}) & ovf_mask);
        bar_data = in_data;
        case (in_op)
            OP_SLL:  bar_data = in_data << eff_cnt;
            OP_SRL:  bar_data = in_data >> eff_cnt;
            OP_SLA:  bar_data = in_data <<< eff_cnt;
            OP_SRA:  bar_data = WIDTH'($signed(in_data) >>> eff_cnt);
            OP_ROL:  bar_data = (in_data << eff_cnt) | (in_data >> (32'(WIDTH) - eff_amt));
            OP_ROR:  bar_data = (in_data >> eff_cnt) | (in_data << (32'(WIDTH) - eff_amt));
            default: bar_data = in_data;
        endcase
    end
`else
    logic [2:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             msb_q;
    logic [WIDTH-1:0] step_data;

    // One-bit step of the latched operation
    always_comb begin
        step_data = data_q;
        case (op_q)
            OP_SLL, OP_SLA: step_data = {data_q[WIDTH-2:0], 1'b0};
            OP_SRL:         step_data = {1'b0, data_q[WIDTH-1:1]};
            OP_SRA:         step_data = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
            OP_ROL:         step_data = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            OP_ROR:         step_data = {data_q[0], data_q[WIDTH-1:1]};
            default:        step_data = data_q;
        endcase
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, count down in SHIFT, wait for the consumer in HOLD
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
`ifdef SHIFT_SEQ_BARREL_EN
                    state_nxt = HOLD;
`else
                    if (is_pass || eff_cnt == '0) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = SHIFT;
                    end
`endif
                end
            end
            SHIFT: begin
`ifdef SHIFT_SEQ_BARREL_EN
                state_nxt = HOLD;
`else
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = HOLD;
                end
`endif
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the command on accept, then step it while in SHIFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ovf_q  <= 1'b0;
`ifndef SHIFT_SEQ_BARREL_EN
            op_q   <= '0;
            cnt_q  <= '0;
            msb_q  <= 1'b0;
`endif
        end else if (accept) begin
`ifdef SHIFT_SEQ_BARREL_EN
            data_q <= bar_data;
            ovf_q  <= (in_op == OP_SLA) && bar_ovf;
`else
            data_q <= in_data;
            ovf_q  <= 1'b0;
            op_q   <= in_op;
            cnt_q  <= eff_cnt;
            msb_q  <= in_data[WIDTH-1];
`endif
        end
`ifndef SHIFT_SEQ_BARREL_EN
        else if (state == SHIFT) begin
            data_q <= step_data;
            cnt_q  <= cnt_q - CNT_W'(1);
            if (op_q == OP_SLA && step_data[WIDTH-1] != msb_q) begin
                ovf_q <= 1'b1;
            end
        end
`endif
    end

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == HOLD);
    assign busy       = (state != IDLE);
    assign out_data   = data_q;
    assign out_parity = ^data_q;
    assign out_zero   = ~|data_q;
    assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_shift_seq.sv
// tb_shift_seq: directed and back-to-back stimulus for shift_seq with a behavioural reference model.
// Latency: expectations follow the build (iterative, or 1 edge with SHIFT_SEQ_BARREL_EN).
// Backpressure: out_ready is held low, pulsed, and randomised to exercise HOLD.
module tb_shift_seq;
    localparam int W  = 9;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_op = '0;
    logic [AW-1:0] in_amt = '0;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_parity;
    logic          out_zero;
    logic          out_ovf;
    logic          busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int n_done  = 0;
    bit mon_en  = 1'b0;

    typedef struct {
        logic [W-1:0] data;
        logic         ovf;
        int           due;
        bit           seen;
    } exp_t;
    exp_t q[$];

    shift_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_amt(in_amt), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .out_zero(out_zero), .out_ovf(out_ovf), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand value
    function automatic void model(input logic [2:0] op, input logic [3:0] amt, input logic [8:0] d,
                                  output logic [8:0] r, output logic ovf, output int lat);
        int dv, e, p, sv, qv;
        dv  = int'(d);
        e   = int'(amt);
        ovf = 1'b0;
        r   = d;
        if (op == 3'd4 || op == 3'd5) e = e % W;
        else if (e > W) e = W;
        if (op >= 3'd6) e = 0;
        p = 2 ** e;
        case (op)
            3'd0, 3'd2: r = 9'((dv * p) % 512);
            3'd1:       r = 9'(dv / p);
            3'd3: begin
                sv = (dv >= 256) ? dv - 512 : dv;
                qv = sv / p;
                if (sv < 0 && (sv % p) != 0) qv = qv - 1;
                r = 9'(qv);
            end
            3'd4: r = 9'((dv * p) % 512 + dv / (2 ** (W - e)));
            3'd5: r = 9'(dv / p + (dv * (2 ** (W - e))) % 512);
            default: r = d;
        endcase
        if (op == 3'd2) begin
            for (int k = 1; k <= e; k++) begin
                if (((dv * (2 ** k)) % 512) / 256 != dv / 256) ovf = 1'b1;
            end
        end
`ifdef SHIFT_SEQ_BARREL_EN
        lat = 1;
`else
        lat = (e == 0) ? 1 : e + 1;
`endif
    endfunction

    function automatic int exp_lat(input int n);
`ifdef SHIFT_SEQ_BARREL_EN
        return (n >= 1) ? 1 : 0;
`else
        return n;
`endif
    endfunction

    always @(negedge rst_n) q.delete();

    // Compare process: every cycle, DUT outputs against the model queue
    always @(negedge clk) begin
        logic [8:0] r;
        logic       o;
        int         l;
        if (rst_n && mon_en) begin
            chk_eq("busy_vs_ready", busy, !in_ready);
            if (q.size() > 0 && !q[0].seen && cyc == q[0].due) begin
                chk_eq("latency", out_valid, 1);
                if (out_valid) q[0].seen = 1'b1;
                else q.pop_front();
            end else if (q.size() == 0 || !q[0].seen) begin
                chk_eq("no_early_valid", out_valid, 0);
            end
            if (q.size() > 0 && q[0].seen) begin
                chk_eq("valid_held", out_valid, 1);
                chk_eq("data", out_data, q[0].data);
                chk_eq("parity", out_parity, $countones(q[0].data) % 2);
                chk_eq("zero", out_zero, q[0].data == 0);
                chk_eq("ovf", out_ovf, q[0].ovf);
                chk_eq("ready_in_hold", in_ready, 0);
                if (out_valid && out_ready) begin
                    q.pop_front();
                    n_done++;
                end else if (!out_valid) begin
                    q.pop_front();
                end
            end
            if (in_valid && in_ready) begin
                model(in_op, in_amt, in_data, r, o, l);
                q.push_back('{data: r, ovf: o, due: cyc + l, seen: 1'b0});
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] amt, input logic [8:0] d);
        bit rdy;
        int n;
        n = 0;
        in_valid = 1'b1; in_op = op; in_amt = amt; in_data = d;
        do begin
            rdy = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 50);
        chk_eq("accept", rdy, 1);
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_amt   = 4'($urandom);
        in_data  = 9'($urandom);
    endtask

    task automatic run_cmd(input string name, input logic [2:0] op, input logic [3:0] amt, input logic [8:0] d,
                           input logic [8:0] xd, input logic xovf, input logic xpar, input int lat_iter, input int hold);
        int edges;
        send(op, amt, d);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk_eq({name, "_lat"}, edges, exp_lat(lat_iter));
        chk_eq({name, "_data"}, out_data, xd);
        chk_eq({name, "_ovf"}, out_ovf, xovf);
        chk_eq({name, "_par"}, out_parity, xpar);
        chk_eq({name, "_zero"}, out_zero, xd == 0);
        repeat (hold) begin
            @(posedge clk); #1;
            chk_eq({name, "_hold_data"}, out_data, xd);
            chk_eq({name, "_hold_rdy"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk_eq({name, "_release"}, in_ready, 1);
    endtask

    task automatic chk_reset(input string name);
        chk_eq({name, "_in_ready"}, in_ready, 1);
        chk_eq({name, "_out_valid"}, out_valid, 0);
        chk_eq({name, "_out_data"}, out_data, 0);
        chk_eq({name, "_parity"}, out_parity, 0);
        chk_eq({name, "_zero"}, out_zero, 1);
        chk_eq({name, "_ovf"}, out_ovf, 0);
        chk_eq({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, guard, base, n;
        #1 rst_n = 1'b0;
        #1 chk_reset("rst");
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        //       name      op    amt    data    result  ovf  par  lat hold
        run_cmd("sra",   3'd3, 4'd2,  9'h180, 9'h1E0, 0,   0,   3,  0);
        run_cmd("rol",   3'd4, 4'd1,  9'h101, 9'h003, 0,   0,   2,  0);
        run_cmd("ror",   3'd5, 4'd10, 9'h101, 9'h180, 0,   0,   2,  0);
        run_cmd("sla",   3'd2, 4'd1,  9'h0C0, 9'h180, 1,   0,   2,  0);
        run_cmd("sll",   3'd0, 4'd12, 9'h0C0, 9'h000, 0,   0,   10, 0);
        run_cmd("pass",  3'd6, 4'd7,  9'h0A5, 9'h0A5, 0,   0,   1,  5);
        run_cmd("pass7", 3'd7, 4'd15, 9'h001, 9'h001, 0,   1,   1,  0);
        run_cmd("srl0",  3'd1, 4'd0,  9'h1AB, 9'h1AB, 0,   0,   1,  0);
        run_cmd("slasat",3'd2, 4'd9,  9'h1FF, 9'h000, 1,   0,   10, 0);
        run_cmd("srasat",3'd3, 4'd15, 9'h100, 9'h1FF, 0,   1,   10, 2);

        // Abort an SRL mid-flight with an asynchronous reset pulse
        send(3'd1, 4'd8, 9'h1FF);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("abort");
        @(posedge clk); #1;
        chk_reset("abort_held");
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            chk_eq("abort_no_valid", out_valid, 0);
        end
        run_cmd("srl_after", 3'd1, 4'd8, 9'h100, 9'h001, 0, 1, 9, 0);

        // Back-to-back: in_valid held high, a fresh command after each accept
        base = n_done;
        sent = 0;
        guard = 0;
        in_valid = 1'b1;
        in_op = 3'($urandom_range(0, 7)); in_amt = 4'($urandom_range(0, 15)); in_data = 9'($urandom);
        while (sent < 200 && guard < 20000) begin
            bit acc;
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc) begin
                sent++;
                in_op = 3'($urandom_range(0, 7)); in_amt = 4'($urandom_range(0, 15)); in_data = 9'($urandom);
            end
        end
        in_valid = 1'b0;
        chk_eq("b2b_sent", sent, 200);
        out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk_eq("b2b_drain", q.size(), 0);
        chk_eq("b2b_done", n_done - base, 200);

        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
